gerador_veiculo: RTL

- Weigh-in-motion front end that produces the vehicle word consumed by `circuito`, the existing combinational classifier.
- While a vehicle crosses the station, it counts axle-sensor edges and accumulates per-axle weight samples.
- When the vehicle leaves, it presents the saturated 4-bit weight on p3..p0 and the 2-bit axle code on e1..e0, with a valid/ready handshake.

---
 rtl/gerador_veiculo.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gerador_veiculo.sv
// -----------------------------------------------------------------------------
// gerador_veiculo
//
// Weigh-in-motion front end. While a vehicle is on the station it counts
// axle-sensor rising edges and accumulates the per-axle weight samples. When
// the vehicle leaves, it presents the saturated 4-bit weight (p3..p0) and the
// 2-bit axle code (e1..e0) to the downstream classifier with a valid/ready
// handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   presenca     vehicle-presence sensor (high while a vehicle is present)
//   sensor_eixo  axle sensor, one rising edge per axle
//   peso_eixo    [3:0] weight of the current axle, taken on the axle edge
//   pronto       consumer ready
//   p3..p0       weight word, MSB first (min(sum, 15))
//   e1..e0       axle code (min(count, 5) - 2; 00 when fewer than 2 axles)
//   valido       output word valid
//   erro         measurement invalid (timeout or fewer than 2 axles)
//   overrun      sticky: a vehicle arrived while a word was pending
//
// Parameters:
//   TIMEOUT      MEASURE cycles before the measurement is aborted with erro
//   DEB_CYCLES   cycles the axle level must be stable (DEBOUNCE_EN only)
//
// Build option:
//   DEBOUNCE_EN  when defined, sensor_eixo is synchronised (2 flops) and
//                debounced before edge detection; peso_eixo must then be held
//                for 2+DEB_CYCLES cycles after each axle edge. When undefined,
//                sensor_eixo is assumed synchronous to clk.
// -----------------------------------------------------------------------------
module gerador_veiculo #(
  parameter int TIMEOUT    = 1000,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       presenca,
  input  logic       sensor_eixo,
  input  logic [3:0] peso_eixo,
  input  logic       pronto,
  output logic       p3,
  output logic       p2,
  output logic       p1,
  output logic       p0,
  output logic       e1,
  output logic       e0,
  output logic       valido,
  output logic       erro,
  output logic       overrun
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  if (TIMEOUT < 2 || DEB_CYCLES < 1) begin : g_bad_params
    $error("gerador_veiculo: TIMEOUT must be >= 2 and DEB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Axle level seen by the edge detector
  // ---------------------------------------------------------------------------
  logic eixo_lvl;

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q, deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // The counter runs only while the synchronised level differs from the
  // accepted one; any return to the accepted level restarts the window.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sensor_eixo;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign eixo_lvl = deb_q;
`else
  assign eixo_lvl = sensor_eixo;
`endif

  // ---------------------------------------------------------------------------
  // Measurement / hold state
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic          pres_prev_q, eixo_prev_q;
  logic [4:0]    sum_q, sum_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    p_q, p_d;
  logic [1:0]    e_q, e_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic          overrun_q, overrun_d;

  logic       pres_rise, axle_rise;
  logic [5:0] sum_add;
  logic [4:0] sum_next;
  logic [2:0] cnt_next;

  assign pres_rise = presenca & ~pres_prev_q;
  assign axle_rise = eixo_lvl & ~eixo_prev_q;

  // Totals including an axle edge in the current cycle, so an axle that
  // coincides with the vehicle leaving is still part of the final word.
  // The 5-bit sum saturates at 31 so a wrap can never fake a light vehicle.
  assign sum_add  = {1'b0, sum_q} + {2'b00, peso_eixo};
  assign sum_next = !axle_rise ? sum_q :
                    (sum_add[5] ? 5'd31 : sum_add[4:0]);
  assign cnt_next = (axle_rise && cnt_q != 3'd7) ? cnt_q + 3'd1 : cnt_q;

  // NOTE: every always_comb output gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    p_d       = p_q;
    e_d       = e_q;
    valido_d  = valido_q;
    erro_d    = erro_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (pres_rise) begin
          sum_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        sum_d   = sum_next;
        cnt_d   = cnt_next;
        timer_d = timer_q + TW'(1);
        if (!presenca) begin
          state_d  = HOLD;
          valido_d = 1'b1;
          p_d      = (sum_next > 5'd15) ? 4'hF : sum_next[3:0];
          if (cnt_next < 3'd2) begin
            erro_d = 1'b1;
            e_d    = 2'b00;
          end else begin
            erro_d = 1'b0;
            e_d    = (cnt_next >= 3'd5) ? 2'b11 : 2'(cnt_next - 3'd2);
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d  = HOLD;
          valido_d = 1'b1;
          erro_d   = 1'b1;
          p_d      = 4'h0;
          e_d      = 2'b00;
        end
      end

      HOLD: begin
        // A new vehicle cannot be measured while the word is pending; it is
        // dropped and flagged. Going to IDLE with presenca already high means
        // no fresh rising edge, so the dropped vehicle is never measured.
        if (pres_rise) overrun_d = 1'b1;
        if (pronto) begin
          valido_d = 1'b0;
          erro_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pres_prev_q <= 1'b0;
      eixo_prev_q <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      p_q         <= '0;
      e_q         <= '0;
      valido_q    <= 1'b0;
      erro_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pres_prev_q <= presenca;
      eixo_prev_q <= eixo_lvl;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      p_q         <= p_d;
      e_q         <= e_d;
      valido_q    <= valido_d;
      erro_q      <= erro_d;
      overrun_q   <= overrun_d;
    end
  end

  assign {p3, p2, p1, p0} = p_q;
  assign {e1, e0}         = e_q;
  assign valido           = valido_q;
  assign erro             = erro_q;
  assign overrun          = overrun_q;

endmodule
